// File: rtl/i2c_slave_responder.sv
// I2C target with a small byte register file: write, pointer-set and sequential read.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_slave_responder #(
  parameter logic [6:0] pSlaveAdrs  = 7'h50,
  parameter int         pRegNum     = 16,
  parameter int         pRegAdrsBit = 4
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic                   iI2CScl,
  input  logic                   iI2CSda,
  output logic                   oI2CSdaOe,
  input  logic [pRegAdrsBit-1:0] iSysRegAdrs,
  input  logic [7:0]             iSysRegWd,
  input  logic                   iSysRegWe,
  output logic [7:0]             oSysRegRd,
  output logic                   oWrVd,
  output logic [pRegAdrsBit-1:0] oWrAdrs,
  output logic                   oBusy
);

  typedef enum logic [3:0] {
    stIdle, stAddr, stAckAddr, stPtr, stAckPtr, stWrData, stAckWr, stRdData, stRdAck, stIgnore
  } stateT;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [pRegAdrsBit-1:0] nextPtr(input logic [pRegAdrsBit-1:0] p);
    if (int'(p) == pRegNum - 1) return '0;
    return p + 1'b1;
  endfunction

  logic sclS1, sclS2, sdaS1, sdaS2;
  logic sclC, sdaC, sclPrev, sdaPrev;

  // Synchronisers idle high so a released bus produces no edge out of reset
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      {sclS1, sclS2, sdaS1, sdaS2} <= '1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclS1   <= iI2CScl;
      sclS2   <= sclS1;
      sdaS1   <= iI2CSda;
      sdaS2   <= sdaS1;
      sclPrev <= sclC;
      sdaPrev <= sdaC;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] sclHist, sdaHist;
  logic       sclMaj, sdaMaj;

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      sclHist <= '1;
      sdaHist <= '1;
      sclMaj  <= 1'b1;
      sdaMaj  <= 1'b1;
    end else begin
      sclHist <= {sclHist[0], sclS2};
      sdaHist <= {sdaHist[0], sdaS2};
      sclMaj  <= maj3(sclS2, sclHist[0], sclHist[1]);
      sdaMaj  <= maj3(sdaS2, sdaHist[0], sdaHist[1]);
    end
  end

  assign sclC = sclMaj;
  assign sdaC = sdaMaj;
`else
  assign sclC = sclS2;
  assign sdaC = sdaS2;
`endif

  logic sclRise, sclFall, startDet, stopDet;
  assign sclRise  = sclC & ~sclPrev;
  assign sclFall  = ~sclC & sclPrev;
  assign startDet = sclC & sclPrev & sdaPrev & ~sdaC;
  assign stopDet  = sclC & sclPrev & ~sdaPrev & sdaC;

  stateT                  state;
  logic [3:0]             bitCnt;
  logic [7:0]             shiftReg, txReg, rxByte;
  logic [pRegAdrsBit-1:0] ptr;
  logic [7:0]             regFile [pRegNum];

  assign rxByte    = {shiftReg[6:0], sdaC};
  assign oSysRegRd = regFile[iSysRegAdrs];

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      state     <= stIdle;
      bitCnt    <= '0;
      shiftReg  <= '0;
      txReg     <= '0;
      ptr       <= '0;
      oI2CSdaOe <= 1'b0;
      oWrVd     <= 1'b0;
      oWrAdrs   <= '0;
      oBusy     <= 1'b0;
      for (int i = 0; i < pRegNum; i++) regFile[i] <= '0;
    end else begin
      oWrVd <= 1'b0;
      // System write first so a same-index bus write below overrides it
      if (iSysRegWe) regFile[iSysRegAdrs] <= iSysRegWd;
      if (stopDet) begin
        state     <= stIdle;
        oI2CSdaOe <= 1'b0;
        oBusy     <= 1'b0;
      end else if (startDet) begin
        state     <= stAddr;
        bitCnt    <= '0;
        oI2CSdaOe <= 1'b0;
        oBusy     <= 1'b1;
      end else begin
        case (state)
          stAddr, stPtr, stWrData: begin
            if (sclRise && bitCnt != 4'd8) begin
              shiftReg <= rxByte;
              bitCnt   <= bitCnt + 4'd1;
              if (bitCnt == 4'd7 && state == stPtr) ptr <= rxByte[pRegAdrsBit-1:0];
              if (bitCnt == 4'd7 && state == stWrData) begin
                regFile[ptr] <= rxByte;
                oWrVd        <= 1'b1;
                oWrAdrs      <= ptr;
                ptr          <= nextPtr(ptr);
              end
            end else if (sclFall && bitCnt == 4'd8) begin
              bitCnt <= '0;
              if (state == stAddr && shiftReg[7:1] != pSlaveAdrs) begin
                state <= stIgnore;
              end else begin
                oI2CSdaOe <= 1'b1;
                state     <= (state == stAddr) ? stAckAddr :
                             (state == stPtr)  ? stAckPtr  : stAckWr;
              end
            end
          end
          stAckAddr: begin
            if (sclFall) begin
              if (shiftReg[0]) begin
                txReg     <= regFile[ptr];
                oI2CSdaOe <= ~regFile[ptr][7];
                state     <= stRdData;
              end else begin
                oI2CSdaOe <= 1'b0;
                state     <= stPtr;
              end
            end
          end
          stAckPtr, stAckWr: begin
            if (sclFall) begin
              oI2CSdaOe <= 1'b0;
              state     <= stWrData;
            end
          end
          stRdData: begin
            if (sclRise) begin
              bitCnt <= bitCnt + 4'd1;
            end else if (sclFall) begin
              if (bitCnt == 4'd8) begin
                bitCnt    <= '0;
                oI2CSdaOe <= 1'b0;
                state     <= stRdAck;
              end else begin
                txReg     <= {txReg[6:0], 1'b0};
                oI2CSdaOe <= ~txReg[6];
              end
            end
          end
          stRdAck: begin
            // bitCnt marks that the master ACKed and the next byte is due
            if (sclRise) begin
              if (sdaC) begin
                state <= stIgnore;
              end else begin
                ptr    <= nextPtr(ptr);
                bitCnt <= 4'd1;
              end
            end else if (sclFall && bitCnt == 4'd1) begin
              bitCnt    <= '0;
              txReg     <= regFile[ptr];
              oI2CSdaOe <= ~regFile[ptr][7];
              state     <= stRdData;
            end
          end
          default: oI2CSdaOe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a behavioural I2C master with hand-computed expectations.
`timescale 1ns/1ps
module tb_i2c_slave_responder;
  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       scl = 1'b1;
  logic       mSda = 1'b1;
  logic [3:0] sysAdrs = '0;
  logic [7:0] sysWd = '0;
  logic       sysWe = 1'b0;
  logic       sdaOe, wrVd, busy;
  logic [7:0] sysRd;
  logic [3:0] wrAdrs;
  logic       busSda;

  int tests = 0;
  int fails = 0;
  int wrCount = 0;
  int oeCount = 0;
  logic [3:0] wrLog [64];

  assign busSda = mSda & ~sdaOe;

  i2c_slave_responder dut (
    .iSysClk(clk), .iSysRst(rstN), .iI2CScl(scl), .iI2CSda(busSda), .oI2CSdaOe(sdaOe),
    .iSysRegAdrs(sysAdrs), .iSysRegWd(sysWd), .iSysRegWe(sysWe), .oSysRegRd(sysRd),
    .oWrVd(wrVd), .oWrAdrs(wrAdrs), .oBusy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrVd) begin
      wrLog[wrCount % 64] = wrAdrs;
      wrCount = wrCount + 1;
    end
    if (sdaOe) oeCount = oeCount + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clockBit(input logic v, input logic glitch, output logic s);
    waitClk(Q); mSda = v;
    waitClk(Q); scl = 1'b1;
    if (glitch) begin
      waitClk(2); scl = 1'b0;
      waitClk(1); scl = 1'b1;
      waitClk(Q - 3);
    end else begin
      waitClk(Q);
    end
    s = busSda;
    waitClk(Q); scl = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic glitchMsb, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], glitchMsb && i == 7, s);
    clockBit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recvByte(input logic nack, output logic [7:0] b, output logic ackSlot);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, 1'b0, s);
      b[i] = s;
    end
    clockBit(nack, 1'b0, s);
    ackSlot = s;
  endtask

  task automatic startCond();
    waitClk(Q); mSda = 1'b1;
    waitClk(Q); scl = 1'b1;
    waitClk(Q); mSda = 1'b0;
    waitClk(Q); scl = 1'b0;
  endtask

  task automatic stopCond();
    waitClk(Q); mSda = 1'b0;
    waitClk(Q); scl = 1'b1;
    waitClk(Q); mSda = 1'b1;
    waitClk(2 * Q);
  endtask

  task automatic test_reset();
    waitClk(3);
    tests++; if (sdaOe !== 1'b0) begin fails++; $display("FAIL rst_oe: got %b want 0", sdaOe); end
    tests++; if (wrVd !== 1'b0) begin fails++; $display("FAIL rst_wrvd: got %b want 0", wrVd); end
    tests++; if (wrAdrs !== 4'h0) begin fails++; $display("FAIL rst_wradrs: got %h want 0", wrAdrs); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    sysAdrs = 4'd3; #1;
    tests++; if (sysRd !== 8'h00) begin fails++; $display("FAIL rst_reg3: got %h want 00", sysRd); end
    waitClk(1); rstN = 1'b1;
    waitClk(4);
  endtask

  task automatic test_write();
    logic ack;
    int base;
    logic [7:0] bytes [4];
    bytes = '{8'hA0, 8'h03, 8'h5A, 8'hC3};
    base = wrCount;
    startCond();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_start: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      sendByte(bytes[i], 1'b0, ack);
      tests++; if (ack !== 1'b1) begin fails++; $display("FAIL wr_ack%0d: got %b want 1", i, ack); end
    end
    stopCond();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
    tests++; if (wrCount - base !== 2) begin fails++; $display("FAIL wr_pulses: got %0d want 2", wrCount - base); end
    tests++; if (wrLog[base % 64] !== 4'h3) begin fails++; $display("FAIL wr_adrs0: got %h want 3", wrLog[base % 64]); end
    tests++; if (wrLog[(base + 1) % 64] !== 4'h4) begin fails++; $display("FAIL wr_adrs1: got %h want 4", wrLog[(base + 1) % 64]); end
    sysAdrs = 4'd3; #1;
    tests++; if (sysRd !== 8'h5A) begin fails++; $display("FAIL wr_reg3: got %h want 5a", sysRd); end
    sysAdrs = 4'd4; #1;
    tests++; if (sysRd !== 8'hC3) begin fails++; $display("FAIL wr_reg4: got %h want c3", sysRd); end
  endtask

  task automatic test_read();
    logic ack, slot;
    logic [7:0] b;
    startCond();
    sendByte(8'hA0, 1'b0, ack);
    sendByte(8'h03, 1'b0, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL rd_ptr_ack: got %b want 1", ack); end
    startCond();
    sendByte(8'hA1, 1'b0, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
    recvByte(1'b0, b, slot);
    tests++; if (b !== 8'h5A) begin fails++; $display("FAIL rd_byte0: got %h want 5a", b); end
    recvByte(1'b1, b, slot);
    tests++; if (b !== 8'hC3) begin fails++; $display("FAIL rd_byte1: got %h want c3", b); end
    tests++; if (slot !== 1'b1) begin fails++; $display("FAIL rd_nack_slot: got %b want 1", slot); end
    waitClk(Q);
    tests++; if (sdaOe !== 1'b0) begin fails++; $display("FAIL rd_release: got %b want 0", sdaOe); end
    stopCond();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    int wrBase, oeBase;
    wrBase = wrCount;
    oeBase = oeCount;
    startCond();
    sendByte(8'hA2, 1'b0, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wa_addr_ack: got %b want 0", ack); end
    sendByte(8'h03, 1'b0, ack);
    sendByte(8'h77, 1'b0, ack);
    tests++; if (ack !== 1'b0) begin fails++; $display("FAIL wa_data_ack: got %b want 0", ack); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL wa_busy: got %b want 1", busy); end
    stopCond();
    tests++; if (oeCount !== oeBase) begin fails++; $display("FAIL wa_oe_cycles: got %0d want 0", oeCount - oeBase); end
    tests++; if (wrCount !== wrBase) begin fails++; $display("FAIL wa_wrvd: got %0d want 0", wrCount - wrBase); end
    sysAdrs = 4'd3; #1;
    tests++; if (sysRd !== 8'h5A) begin fails++; $display("FAIL wa_reg3: got %h want 5a", sysRd); end
  endtask

  task automatic test_wrap();
    logic ack;
    int base;
    base = wrCount;
    startCond();
    sendByte(8'hA0, 1'b0, ack);
    sendByte(8'h0F, 1'b0, ack);
    sendByte(8'h11, 1'b0, ack);
    sendByte(8'h22, 1'b0, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL wrap_ack: got %b want 1", ack); end
    stopCond();
    tests++; if (wrLog[(base + 1) % 64] !== 4'h0) begin fails++; $display("FAIL wrap_adrs: got %h want 0", wrLog[(base + 1) % 64]); end
    sysAdrs = 4'd15; #1;
    tests++; if (sysRd !== 8'h11) begin fails++; $display("FAIL wrap_reg15: got %h want 11", sysRd); end
    sysAdrs = 4'd0; #1;
    tests++; if (sysRd !== 8'h22) begin fails++; $display("FAIL wrap_reg0: got %h want 22", sysRd); end
  endtask

  task automatic test_sys_port();
    logic ack, slot;
    logic [7:0] b;
    int base;
    base = wrCount;
    sysAdrs = 4'd7; sysWd = 8'h99; sysWe = 1'b1;
    waitClk(1); sysWe = 1'b0; #1;
    tests++; if (sysRd !== 8'h99) begin fails++; $display("FAIL sys_rd: got %h want 99", sysRd); end
    tests++; if (wrCount !== base) begin fails++; $display("FAIL sys_wrvd: got %0d want 0", wrCount - base); end
    startCond();
    sendByte(8'hA0, 1'b0, ack);
    sendByte(8'h07, 1'b0, ack);
    startCond();
    sendByte(8'hA1, 1'b0, ack);
    recvByte(1'b1, b, slot);
    stopCond();
    tests++; if (b !== 8'h99) begin fails++; $display("FAIL sys_bus_read: got %h want 99", b); end
  endtask

  task automatic test_glitch();
    logic ack;
    logic [7:0] expect5;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    expect5 = 8'h5A;
`else
    expect5 = 8'h2D;
`endif
    startCond();
    sendByte(8'hA0, 1'b0, ack);
    sendByte(8'h05, 1'b0, ack);
    sendByte(8'h5A, 1'b1, ack);
    stopCond();
    sysAdrs = 4'd5; #1;
    tests++; if (sysRd !== expect5) begin fails++; $display("FAIL glitch_reg5: got %h want %h", sysRd, expect5); end
    sysAdrs = 4'd6; #1;
    tests++; if (sysRd !== 8'h00) begin fails++; $display("FAIL glitch_reg6: got %h want 00", sysRd); end
  endtask

  task automatic test_reset_mid_read();
    logic ack, s;
    startCond();
    sendByte(8'hA0, 1'b0, ack);
    sendByte(8'h04, 1'b0, ack);
    startCond();
    sendByte(8'hA1, 1'b0, ack);
    for (int i = 0; i < 3; i++) clockBit(1'b1, 1'b0, s);
    waitClk(Q); mSda = 1'b1;
    waitClk(Q); scl = 1'b1;
    waitClk(Q);
    tests++; if (sdaOe !== 1'b1) begin fails++; $display("FAIL mr_bit4_drive: got %b want 1", sdaOe); end
    rstN = 1'b0; #1;
    tests++; if (sdaOe !== 1'b0) begin fails++; $display("FAIL mr_release: got %b want 0", sdaOe); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mr_busy: got %b want 0", busy); end
    sysAdrs = 4'd4; #1;
    tests++; if (sysRd !== 8'h00) begin fails++; $display("FAIL mr_reg4: got %h want 00", sysRd); end
    waitClk(3); scl = 1'b0;
    waitClk(Q); rstN = 1'b1;
    waitClk(Q);
    startCond();
    sendByte(8'hA0, 1'b0, ack);
    tests++; if (ack !== 1'b1) begin fails++; $display("FAIL mr_ack_after: got %b want 1", ack); end
    stopCond();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_wrap();
    test_sys_port();
    test_glitch();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
